// File: rtl/raster_pkg.sv
// rtl/raster_pkg.sv - shared raster timing constants, totals helpers and sync polarity
package raster_pkg;

  // Default 640x480 VGA timing (pixels / lines)
  localparam int VGA_HACTIVE = 640;
  localparam int VGA_HFP     = 16;
  localparam int VGA_HSYNC   = 96;
  localparam int VGA_HBP     = 48;
  localparam int VGA_VACTIVE = 480;
  localparam int VGA_VFP     = 10;
  localparam int VGA_VSYNC   = 2;
  localparam int VGA_VBP     = 33;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  function automatic int htotal(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int vtotal(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - divides the system clock down to a one-clock pixel tick strobe
module tick_divider #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt;

  // Phase counter runs 0..TICK_DIV-1 while enabled; restart parks it at phase 0
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      tick_cnt <= '0;
    end else if (en) begin
      tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + TW'(1);
    end
  end

  // A restart cycle never advances the raster, even on the last phase
  assign tick = en && !reset && !restart && (tick_cnt == LAST);

endmodule

// File: rtl/raster_timing_gen.sv
// rtl/raster_timing_gen.sv - raster scan counters, sync/active decodes and line/frame pulses
module raster_timing_gen
  import raster_pkg::*;
#(
  parameter int HACTIVE  = VGA_HACTIVE,
  parameter int HFP      = VGA_HFP,
  parameter int HSYNC    = VGA_HSYNC,
  parameter int HBP      = VGA_HBP,
  parameter int VACTIVE  = VGA_VACTIVE,
  parameter int VFP      = VGA_VFP,
  parameter int VSYNC    = VGA_VSYNC,
  parameter int VBP      = VGA_VBP,
  parameter int CW       = 11,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int TICK_DIV = 4,
  parameter int FCW      = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           restart,
  output logic           pix_tick,
  output logic [CW-1:0]  hcount,
  output logic [CW-1:0]  vcount,
  output logic           hsync,
  output logic           vsync,
  output logic           video_on,
  output logic           line_start,
  output logic           line_end,
  output logic           frame_start,
  output logic           frame_end,
  output logic [FCW-1:0] frame_count
);

  localparam int HTOTAL = htotal(HACTIVE, HFP, HSYNC, HBP);
  localparam int VTOTAL = vtotal(VACTIVE, VFP, VSYNC, VBP);

  if (TICK_DIV < 1) begin : g_bad_div
    $error("raster_timing_gen: TICK_DIV must be at least 1");
  end
  if (HSYNC < 1 || VSYNC < 1) begin : g_bad_sync
    $error("raster_timing_gen: sync widths must be non-zero");
  end
  if (longint'(HTOTAL - 1) > ((longint'(1) << CW) - 1) ||
      longint'(VTOTAL - 1) > ((longint'(1) << CW) - 1)) begin : g_bad_cw
    $error("raster_timing_gen: CW too narrow for the raster totals");
  end

  localparam sync_pol_e HPOL = sync_pol_e'(HS_POL);
  localparam sync_pol_e VPOL = sync_pol_e'(VS_POL);

  localparam logic [CW-1:0] H_LAST     = CW'(HTOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(VTOTAL - 1);
  localparam logic [CW-1:0] H_ACT      = CW'(HACTIVE);
  localparam logic [CW-1:0] V_ACT      = CW'(VACTIVE);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(HACTIVE + HFP);
  localparam logic [CW-1:0] H_SYNC_END = CW'(HACTIVE + HFP + HSYNC - 1);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(VACTIVE + VFP);
  localparam logic [CW-1:0] V_SYNC_END = CW'(VACTIVE + VFP + VSYNC - 1);

  logic h_last, v_last, h_first, v_first, in_hsync, in_vsync;

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_divider (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .restart(restart),
    .tick   (pix_tick)
  );

  assign h_last  = (hcount == H_LAST);
  assign v_last  = (vcount == V_LAST);
  assign h_first = (hcount == '0);
  assign v_first = (vcount == '0);

  // Axis counters advance on pix_tick; frame_count survives restart but not reset
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      frame_count <= '0;
    end else if (restart) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_tick) begin
      hcount <= h_last ? '0 : hcount + CW'(1);
      if (h_last) begin
        vcount <= v_last ? '0 : vcount + CW'(1);
        if (v_last) begin
          frame_count <= frame_count + FCW'(1);
        end
      end
    end
  end

  // Region decodes straight off the position registers, no pipelining
  assign in_hsync = (hcount >= H_SYNC_BEG) && (hcount <= H_SYNC_END);
  assign in_vsync = (vcount >= V_SYNC_BEG) && (vcount <= V_SYNC_END);
  assign hsync    = in_hsync ^ (HPOL == SYNC_ACTIVE_LOW);
  assign vsync    = in_vsync ^ (VPOL == SYNC_ACTIVE_LOW);
  assign video_on = (hcount < H_ACT) && (vcount < V_ACT);

  // Pulses qualify the position with the tick so they never stretch while frozen
  assign line_start  = pix_tick && h_first;
  assign line_end    = pix_tick && h_last;
  assign frame_start = pix_tick && h_first && v_first;
  assign frame_end   = pix_tick && h_last && v_last;

endmodule

// File: tb/tb_raster_timing_gen.sv
// tb/tb_raster_timing_gen.sv - directed and randomized checks of raster_timing_gen
module tb_raster_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic restart = 1'b0;
  bit   mon_on = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pt;
    logic [15:0] h;
    logic [15:0] v;
    logic        hs;
    logic        vs;
    logic        von;
    logic        ls;
    logic        le;
    logic        fs;
    logic        fe;
    logic [15:0] fc;
  } obs_t;

  // d0: default VGA timing, TICK_DIV=4, active-low syncs
  logic d0_pt, d0_hs, d0_vs, d0_von, d0_ls, d0_le, d0_fs, d0_fe;
  logic [10:0] d0_h, d0_v;
  logic [15:0] d0_fc;
  raster_timing_gen u_d0 (
    .clk(clk), .reset(reset), .en(en), .restart(restart), .pix_tick(d0_pt),
    .hcount(d0_h), .vcount(d0_v), .hsync(d0_hs), .vsync(d0_vs), .video_on(d0_von),
    .line_start(d0_ls), .line_end(d0_le), .frame_start(d0_fs), .frame_end(d0_fe),
    .frame_count(d0_fc)
  );

  // d1: 15x11 raster, TICK_DIV=1, active-high syncs
  logic d1_pt, d1_hs, d1_vs, d1_von, d1_ls, d1_le, d1_fs, d1_fe;
  logic [4:0] d1_h, d1_v;
  logic [3:0] d1_fc;
  raster_timing_gen #(
    .HACTIVE(8), .HFP(2), .HSYNC(3), .HBP(2), .VACTIVE(6), .VFP(1), .VSYNC(2), .VBP(2),
    .CW(5), .HS_POL(1'b1), .VS_POL(1'b1), .TICK_DIV(1), .FCW(4)
  ) u_d1 (
    .clk(clk), .reset(reset), .en(en), .restart(restart), .pix_tick(d1_pt),
    .hcount(d1_h), .vcount(d1_v), .hsync(d1_hs), .vsync(d1_vs), .video_on(d1_von),
    .line_start(d1_ls), .line_end(d1_le), .frame_start(d1_fs), .frame_end(d1_fe),
    .frame_count(d1_fc)
  );

  // d2: 7x5 raster, TICK_DIV=2, 2-bit frame counter
  logic d2_pt, d2_hs, d2_vs, d2_von, d2_ls, d2_le, d2_fs, d2_fe;
  logic [2:0] d2_h, d2_v;
  logic [1:0] d2_fc;
  raster_timing_gen #(
    .HACTIVE(4), .HFP(1), .HSYNC(1), .HBP(1), .VACTIVE(2), .VFP(1), .VSYNC(1), .VBP(1),
    .CW(3), .HS_POL(1'b0), .VS_POL(1'b0), .TICK_DIV(2), .FCW(2)
  ) u_d2 (
    .clk(clk), .reset(reset), .en(en), .restart(restart), .pix_tick(d2_pt),
    .hcount(d2_h), .vcount(d2_v), .hsync(d2_hs), .vsync(d2_vs), .video_on(d2_von),
    .line_start(d2_ls), .line_end(d2_le), .frame_start(d2_fs), .frame_end(d2_fe),
    .frame_count(d2_fc)
  );

  obs_t a0, a1, a2;
  assign a0 = {d0_pt, 16'(d0_h), 16'(d0_v), d0_hs, d0_vs, d0_von, d0_ls, d0_le, d0_fs, d0_fe, 16'(d0_fc)};
  assign a1 = {d1_pt, 16'(d1_h), 16'(d1_v), d1_hs, d1_vs, d1_von, d1_ls, d1_le, d1_fs, d1_fe, 16'(d1_fc)};
  assign a2 = {d2_pt, 16'(d2_h), 16'(d2_v), d2_hs, d2_vs, d2_von, d2_ls, d2_le, d2_fs, d2_fe, 16'(d2_fc)};

  // Reference state: enabled clocks since last restart, and frames completed before it
  longint ec0 = 0, ec1 = 0, ec2 = 0;
  longint fb0 = 0, fb1 = 0, fb2 = 0;

  function automatic obs_t model_obs(
    input longint ec, input longint fb,
    input longint ha, input longint hf, input longint hsw, input longint hb,
    input longint va, input longint vf, input longint vsw, input longint vb,
    input longint td, input longint fcw, input bit hp, input bit vp,
    input logic en_i, input logic rs_i);
    longint ht, vt, t, pos, h, v;
    obs_t o;
    ht  = ha + hf + hsw + hb;
    vt  = va + vf + vsw + vb;
    t   = ec / td;
    pos = t % (ht * vt);
    h   = pos % ht;
    v   = pos / ht;
    o.pt  = en_i && !rs_i && ((ec % td) == td - 1);
    o.h   = 16'(h);
    o.v   = 16'(v);
    o.hs  = (h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
    o.vs  = (v >= va + vf && v < va + vf + vsw) ? vp : !vp;
    o.von = (h < ha) && (v < va);
    o.ls  = o.pt && (h == 0);
    o.le  = o.pt && (h == ht - 1);
    o.fs  = o.pt && (h == 0) && (v == 0);
    o.fe  = o.pt && (h == ht - 1) && (v == vt - 1);
    o.fc  = 16'((fb + t / (ht * vt)) % (longint'(1) << fcw));
    return o;
  endfunction

  task automatic test_reset();
    @(posedge clk); #1; reset = 1'b1; en = 1'b0; restart = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    @(negedge clk);
    checks++; if (d0_h !== '0 || d0_v !== '0) begin errors++; $display("FAIL reset_pos: got (%0d,%0d) expected (0,0)", d0_h, d0_v); end
    checks++; if (d0_fc !== '0) begin errors++; $display("FAIL reset_fc: got %0d expected 0", d0_fc); end
    checks++; if ({d0_pt, d0_ls, d0_le, d0_fs, d0_fe} !== 5'b0) begin errors++; $display("FAIL reset_pulses: got %b expected 00000", {d0_pt, d0_ls, d0_le, d0_fs, d0_fe}); end
    checks++; if ({d0_hs, d0_vs} !== 2'b11) begin errors++; $display("FAIL reset_sync_low_pol: got %b expected 11", {d0_hs, d0_vs}); end
    checks++; if (d0_von !== 1'b1) begin errors++; $display("FAIL reset_video_on: got %b expected 1", d0_von); end
    checks++; if ({d1_hs, d1_vs} !== 2'b00) begin errors++; $display("FAIL reset_sync_high_pol: got %b expected 00", {d1_hs, d1_vs}); end
    mon_on = 1'b1;
  endtask

  task automatic test_first_tick();
    logic exp_pt;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0; en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp_pt = (k == 4);
      checks++; if (d0_pt !== exp_pt) begin errors++; $display("FAIL first_tick clk%0d: got %b expected %b", k, d0_pt, exp_pt); end
    end
    @(negedge clk);
    checks++; if (d0_h !== 11'd1) begin errors++; $display("FAIL first_advance: got %0d expected 1", d0_h); end
  endtask

  task automatic test_hsync_line();
    int low = 0, von = 0, hmin = 100000, hmax = -1, vbad = 0, ends = 0;
    @(posedge clk); #1; restart = 1'b1; en = 1'b1;
    @(posedge clk); #1; restart = 1'b0;
    for (int c = 0; c < 3200; c++) begin
      @(negedge clk);
      if (d0_hs === 1'b0) begin
        low++;
        if (int'(d0_h) < hmin) hmin = int'(d0_h);
        if (int'(d0_h) > hmax) hmax = int'(d0_h);
      end
      if (d0_von === 1'b1) von++;
      if (d0_v !== '0) vbad++;
      if (d0_le === 1'b1) ends++;
    end
    checks++; if (low != 384) begin errors++; $display("FAIL hsync_width: got %0d clocks expected 384", low); end
    checks++; if (hmin != 656 || hmax != 751) begin errors++; $display("FAIL hsync_span: got %0d..%0d expected 656..751", hmin, hmax); end
    checks++; if (von != 2560) begin errors++; $display("FAIL line_video_on: got %0d clocks expected 2560", von); end
    checks++; if (vbad != 0) begin errors++; $display("FAIL vcount_early: got %0d moved cycles expected 0", vbad); end
    checks++; if (ends != 1) begin errors++; $display("FAIL line_end_count: got %0d expected 1", ends); end
    @(negedge clk);
    checks++; if (d0_h !== '0 || d0_v !== 11'd1) begin errors++; $display("FAIL line_wrap: got (%0d,%0d) expected (0,1)", d0_h, d0_v); end
  endtask

  task automatic test_vsync_frame();
    int vhi = 0, vmin = 100000, vmax = -1, von = 0, fe_n = 0, fe_h = -1, fe_v = -1;
    int fs_c[3];
    int fs_fc[3];
    int fs_n = 0;
    @(posedge clk); #1; restart = 1'b1; en = 1'b1;
    @(posedge clk); #1; restart = 1'b0;
    for (int c = 0; c <= 330; c++) begin
      @(negedge clk);
      if (c < 165) begin
        if (d1_vs === 1'b1) begin
          vhi++;
          if (int'(d1_v) < vmin) vmin = int'(d1_v);
          if (int'(d1_v) > vmax) vmax = int'(d1_v);
        end
        if (d1_von === 1'b1) von++;
        if (d1_fe === 1'b1) begin fe_n++; fe_h = int'(d1_h); fe_v = int'(d1_v); end
      end
      if (d1_fs === 1'b1 && fs_n < 3) begin fs_c[fs_n] = c; fs_fc[fs_n] = int'(d1_fc); fs_n++; end
    end
    checks++; if (vhi != 30 || vmin != 7 || vmax != 8) begin errors++; $display("FAIL vsync_region: got %0d clocks v%0d..%0d expected 30 clocks v7..8", vhi, vmin, vmax); end
    checks++; if (von != 48) begin errors++; $display("FAIL frame_video_on: got %0d expected 48", von); end
    checks++; if (fe_n != 1 || fe_h != 14 || fe_v != 10) begin errors++; $display("FAIL frame_end_pos: got n=%0d (%0d,%0d) expected n=1 (14,10)", fe_n, fe_h, fe_v); end
    checks++;
    if (fs_n != 3) begin
      errors++; $display("FAIL frame_start_count: got %0d expected 3", fs_n);
    end else if (fs_c[0] != 0 || fs_c[1] - fs_c[0] != 165 || fs_c[2] - fs_c[1] != 165) begin
      errors++; $display("FAIL frame_period: got starts at %0d,%0d,%0d expected 0,165,330", fs_c[0], fs_c[1], fs_c[2]);
    end
    checks++; if (fs_n == 3 && ((fs_fc[1] - fs_fc[0]) & 15) != 1) begin errors++; $display("FAIL frame_count_step: got %0d->%0d expected +1", fs_fc[0], fs_fc[1]); end
  endtask

  task automatic test_freeze();
    bit found = 1'b0;
    int bad = 0;
    logic [15:0] fc_hold;
    logic exp_pt;
    logic [10:0] exp_h;
    @(posedge clk); #1; restart = 1'b1; en = 1'b1;
    @(posedge clk); #1; restart = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clk);
      if (d0_h === 11'd99 && d0_pt === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL freeze_reach: got timeout expected hcount 99");
    end else begin
      @(posedge clk); #1; en = 1'b0;
      @(negedge clk);
      fc_hold = d0_fc;
      for (int c = 0; c < 50; c++) begin
        if (c > 0) @(negedge clk);
        checks++;
        if (d0_h !== 11'd100 || d0_v !== '0 || d0_von !== 1'b1 || d0_fc !== fc_hold ||
            {d0_pt, d0_ls, d0_le, d0_fs, d0_fe} !== 5'b0) begin
          errors++; bad++;
          $display("FAIL freeze_hold c%0d: got (%0d,%0d) von=%b fc=%0d pulses=%b expected (100,0) von=1 fc=%0d pulses=00000",
                   c, d0_h, d0_v, d0_von, d0_fc, {d0_pt, d0_ls, d0_le, d0_fs, d0_fe}, fc_hold);
        end
      end
      @(posedge clk); #1; en = 1'b1;
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        exp_pt = (k == 4);
        exp_h  = (k <= 4) ? 11'd100 : 11'd101;
        checks++; if (d0_pt !== exp_pt || d0_h !== exp_h) begin errors++; $display("FAIL resume clk%0d: got pt=%b h=%0d expected pt=%b h=%0d", k, d0_pt, d0_h, exp_pt, exp_h); end
      end
    end
  endtask

  task automatic test_restart();
    bit found = 1'b0;
    logic [3:0] fc_before;
    en = 1'b1;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clk);
      if (d1_v === 5'd9 && d1_h === 5'd12) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL restart_reach: got timeout expected (12,9)");
    end else begin
      fc_before = d1_fc;
      @(posedge clk); #1; restart = 1'b1;
      @(negedge clk);
      checks++; if (d1_pt !== 1'b0 || d0_pt !== 1'b0) begin errors++; $display("FAIL restart_tick_gate: got %b%b expected 00", d1_pt, d0_pt); end
      @(posedge clk); #1; restart = 1'b0;
      @(negedge clk);
      checks++; if (d1_h !== '0 || d1_v !== '0 || d0_h !== '0 || d0_v !== '0) begin errors++; $display("FAIL restart_pos: got d1(%0d,%0d) d0(%0d,%0d) expected (0,0)", d1_h, d1_v, d0_h, d0_v); end
      checks++; if (d1_fc !== fc_before) begin errors++; $display("FAIL restart_keeps_fc: got %0d expected %0d", d1_fc, fc_before); end
    end
    repeat (330) @(posedge clk);
    #1; reset = 1'b1; restart = 1'b1;
    @(posedge clk); #1; reset = 1'b0; restart = 1'b0;
    @(negedge clk);
    checks++; if (d1_fc !== '0 || d0_fc !== '0 || d2_fc !== '0) begin errors++; $display("FAIL reset_restart_fc: got %0d/%0d/%0d expected 0/0/0", d1_fc, d0_fc, d2_fc); end
    checks++; if (d1_h !== '0 || d1_v !== '0) begin errors++; $display("FAIL reset_restart_pos: got (%0d,%0d) expected (0,0)", d1_h, d1_v); end
  endtask

  task automatic test_fc_wrap();
    int fe_n = 0, fs_n = 0;
    @(posedge clk); #1; reset = 1'b1; restart = 1'b0; en = 1'b0;
    @(posedge clk); #1; reset = 1'b0; en = 1'b1;
    for (int c = 0; c < 284; c++) begin
      @(negedge clk);
      if (d2_fe === 1'b1) begin
        checks++; if (d2_fc !== 2'(fe_n)) begin errors++; $display("FAIL fc_at_frame_end #%0d: got %0d expected %0d", fe_n, d2_fc, fe_n % 4); end
        fe_n++;
      end
      if (d2_fs === 1'b1) begin
        checks++; if (d2_fc !== 2'(fs_n)) begin errors++; $display("FAIL fc_at_frame_start #%0d: got %0d expected %0d", fs_n, d2_fc, fs_n % 4); end
        fs_n++;
      end
    end
    checks++; if (fe_n != 4 || fs_n != 5) begin errors++; $display("FAIL fc_wrap_frames: got fe=%0d fs=%0d expected fe=4 fs=5", fe_n, fs_n); end
    checks++; if (d2_fc !== 2'd0) begin errors++; $display("FAIL fc_wrap_value: got %0d expected 0", d2_fc); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      en      = ($urandom_range(0, 9) < 7);
      restart = ($urandom_range(0, 99) < 3);
      reset   = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1; reset = 1'b0; restart = 1'b0; en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({d0_pt, d0_ls, d0_le, d0_fs, d0_fe, d1_pt, d1_ls, d1_le, d1_fs, d1_fe,
           d2_pt, d2_ls, d2_le, d2_fs, d2_fe} !== 15'b0) begin
        errors++; $display("FAIL frozen_pulses c%0d: got %b expected all zero", c,
          {d0_pt, d0_ls, d0_le, d0_fs, d0_fe, d1_pt, d1_ls, d1_le, d1_fs, d1_fe, d2_pt, d2_ls, d2_le, d2_fs, d2_fe});
      end
    end
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk);
        if (reset) begin
          ec0 = 0; ec1 = 0; ec2 = 0; fb0 = 0; fb1 = 0; fb2 = 0;
        end else if (restart) begin
          fb0 = fb0 + (ec0 / 4) / 420000;
          fb1 = fb1 + (ec1 / 1) / 165;
          fb2 = fb2 + (ec2 / 2) / 35;
          ec0 = 0; ec1 = 0; ec2 = 0;
        end else if (en) begin
          ec0++; ec1++; ec2++;
        end
      end
      forever begin
        @(negedge clk);
        if (mon_on && !reset) begin
          checks++;
          if (a0 !== model_obs(ec0, fb0, 640, 16, 96, 48, 480, 10, 2, 33, 4, 16, 1'b0, 1'b0, en, restart)) begin
            errors++; $display("FAIL lockstep_d0 t=%0t: got %h expected %h", $time, a0,
              model_obs(ec0, fb0, 640, 16, 96, 48, 480, 10, 2, 33, 4, 16, 1'b0, 1'b0, en, restart));
          end
          checks++;
          if (a1 !== model_obs(ec1, fb1, 8, 2, 3, 2, 6, 1, 2, 2, 1, 4, 1'b1, 1'b1, en, restart)) begin
            errors++; $display("FAIL lockstep_d1 t=%0t: got %h expected %h", $time, a1,
              model_obs(ec1, fb1, 8, 2, 3, 2, 6, 1, 2, 2, 1, 4, 1'b1, 1'b1, en, restart));
          end
          checks++;
          if (a2 !== model_obs(ec2, fb2, 4, 1, 1, 1, 2, 1, 1, 1, 2, 2, 1'b0, 1'b0, en, restart)) begin
            errors++; $display("FAIL lockstep_d2 t=%0t: got %h expected %h", $time, a2,
              model_obs(ec2, fb2, 4, 1, 1, 1, 2, 1, 1, 1, 2, 2, 1'b0, 1'b0, en, restart));
          end
        end
      end
    join_none

    test_reset();
    test_first_tick();
    test_hsync_line();
    test_vsync_frame();
    test_freeze();
    test_restart();
    test_fc_wrap();
    test_random();

    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
